// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests one word from program memory per fetch_req,
// hands it to the instruction register with a one-cycle load strobe, and tracks pc.
module instruction_fetch #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr_out,
  output logic              ir_load,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_LOAD   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_pc, w_pc_next;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
  logic                r_mem_rd, w_mem_rd_next;
  logic [DATA_W-1:0]   r_instr, w_instr_next;
  logic                r_ir_load, w_ir_load_next;
  logic                r_busy, w_busy_next;
  logic                r_halted, w_halted_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_instr    <= '0;
      r_ir_load  <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_mem_addr <= w_mem_addr_next;
      r_mem_rd   <= w_mem_rd_next;
      r_instr    <= w_instr_next;
      r_ir_load  <= w_ir_load_next;
      r_busy     <= w_busy_next;
      r_halted   <= w_halted_next;
    end
  end

  // Controller inputs only act in IDLE; mem_ack only acts in REQ.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_mem_addr_next = r_mem_addr;
    w_mem_rd_next   = r_mem_rd;
    w_instr_next    = r_instr;
    w_ir_load_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (halt) begin
          w_state_next = S_HALTED;
        end else if (jump) begin
          w_pc_next = jump_addr;
        end else if (fetch_req) begin
          w_state_next    = S_REQ;
          w_mem_rd_next   = 1'b1;
          w_mem_addr_next = r_pc;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          w_state_next   = S_LOAD;
          w_instr_next   = mem_data;
          w_pc_next      = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
          w_mem_rd_next  = 1'b0;
          w_ir_load_next = 1'b1;
        end
      end
      S_LOAD:   w_state_next = S_IDLE;
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_IDLE;
    endcase
    w_busy_next   = (w_state_next == S_REQ) || (w_state_next == S_LOAD);
    w_halted_next = (w_state_next == S_HALTED);
  end

  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_mem_addr;
  assign instr_out = r_instr;
  assign ir_load   = r_ir_load;
  assign pc        = r_pc;
  assign busy      = r_busy;
  assign halted    = r_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a transaction model.
module tb_instruction_fetch;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              fetch_req = 1'b0;
  logic              jump = 1'b0;
  logic [ADDR_W-1:0] jump_addr = '0;
  logic              halt = 1'b0;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] instr_out;
  logic              ir_load;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;

  instruction_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .jump(jump),
    .jump_addr(jump_addr), .halt(halt), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .instr_out(instr_out),
    .ir_load(ir_load), .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: an outstanding read, a pending IR load, or a halt.
  int m_pc = 0, m_addr = 0, m_instr = 0;
  bit m_rd = 0, m_ld = 0, m_halted = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc <= 0; m_addr <= 0; m_instr <= 0;
      m_rd <= 0; m_ld <= 0; m_halted <= 0;
    end else if (m_halted) begin
      m_halted <= 1;
    end else if (m_ld) begin
      m_ld <= 0;
    end else if (m_rd) begin
      if (mem_ack) begin
        m_instr <= int'(mem_data);
        m_pc    <= (m_pc + 1) % (1 << ADDR_W);
        m_rd    <= 0;
        m_ld    <= 1;
      end
    end else if (halt) begin
      m_halted <= 1;
    end else if (jump) begin
      m_pc <= int'(jump_addr);
    end else if (fetch_req) begin
      m_rd   <= 1;
      m_addr <= m_pc;
    end
  end

  always @(negedge clk) begin
    chk("mem_rd",    32'(mem_rd),    32'(m_rd));
    chk("mem_addr",  32'(mem_addr),  32'(m_addr));
    chk("instr_out", 32'(instr_out), 32'(m_instr));
    chk("ir_load",   32'(ir_load),   32'(m_ld));
    chk("pc",        32'(pc),        32'(m_pc));
    chk("busy",      32'(busy),      32'(m_rd || m_ld));
    chk("halted",    32'(halted),    32'(m_halted));
  end

  initial begin
    reset_n = 1'b0;
    repeat (2) step();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_instr", 32'(instr_out), 32'h0);
    chk("rst_model_pc", 32'(m_pc), 32'h0);
    reset_n = 1'b1;

    // Single fetch, ack in the first REQ cycle
    fetch_req = 1; mem_ack = 1; mem_data = 8'hA5; step();
    fetch_req = 0;
    chk("t1_mem_rd", 32'(mem_rd), 32'h1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h0);
    step();
    chk("t1_ir_load", 32'(ir_load), 32'h1);
    chk("t1_instr", 32'(instr_out), 32'hA5);
    chk("t1_pc", 32'(pc), 32'h1);
    chk("t1_model_instr", 32'(m_instr), 32'hA5);
    mem_ack = 0; step();
    chk("t1_ir_drop", 32'(ir_load), 32'h0);
    $display("txn directed_fetch instr=%0h pc=%0h", instr_out, pc);

    // Ack delayed to the 5th REQ cycle
    fetch_req = 1; step(); fetch_req = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_mem_rd", 32'(mem_rd), 32'h1);
      chk("t2_mem_addr", 32'(mem_addr), 32'h1);
      chk("t2_no_load", 32'(ir_load), 32'h0);
      if (i == 4) begin mem_ack = 1; mem_data = 8'h5A; end
      step();
    end
    mem_ack = 0;
    chk("t2_ir_load", 32'(ir_load), 32'h1);
    chk("t2_instr", 32'(instr_out), 32'h5A);
    chk("t2_pc", 32'(pc), 32'h2);
    step();
    chk("t2_ir_once", 32'(ir_load), 32'h0);
    $display("txn delayed_ack instr=%0h pc=%0h", instr_out, pc);

    // pc wrap from 15
    jump = 1; jump_addr = 4'hF; step(); jump = 0;
    chk("t3_pc15", 32'(pc), 32'hF);
    fetch_req = 1; mem_data = 8'h3C; step(); fetch_req = 0;
    mem_ack = 1; step(); mem_ack = 0;
    chk("t3_instr", 32'(instr_out), 32'h3C);
    chk("t3_pc_wrap", 32'(pc), 32'h0);
    step();
    $display("txn wrap instr=%0h pc=%0h", instr_out, pc);

    // jump wins over fetch_req
    jump = 1; fetch_req = 1; jump_addr = 4'h9; step();
    jump = 0; fetch_req = 0;
    chk("t4_pc9", 32'(pc), 32'h9);
    chk("t4_no_rd", 32'(mem_rd), 32'h0);
    fetch_req = 1; step(); fetch_req = 0;
    chk("t4_rd", 32'(mem_rd), 32'h1);
    chk("t4_addr9", 32'(mem_addr), 32'h9);
    $display("txn jump addr=%0h", mem_addr);

    // halt ignored in REQ, honoured in IDLE
    mem_data = 8'h77; halt = 1; step(); step();
    chk("t5_not_halted", 32'(halted), 32'h0);
    chk("t5_still_rd", 32'(mem_rd), 32'h1);
    mem_ack = 1; step(); mem_ack = 0; halt = 0;
    chk("t5_ir_load", 32'(ir_load), 32'h1);
    chk("t5_instr", 32'(instr_out), 32'h77);
    chk("t5_pc", 32'(pc), 32'hA);
    step();
    halt = 1; step(); halt = 0;
    chk("t5_halted", 32'(halted), 32'h1);
    fetch_req = 1; mem_ack = 1;
    repeat (4) begin
      step();
      chk("t5_halt_no_rd", 32'(mem_rd), 32'h0);
    end
    fetch_req = 0; mem_ack = 0;
    $display("txn halt halted=%0b", halted);

    // Reset clears halt; reset pulsed inside REQ aborts the fetch
    reset_n = 0; #2; reset_n = 1;
    chk("t6_unhalt", 32'(halted), 32'h0);
    jump = 1; jump_addr = 4'h5; step(); jump = 0;
    fetch_req = 1; step(); fetch_req = 0;
    chk("t6_addr5", 32'(mem_addr), 32'h5);
    mem_ack = 1; mem_data = 8'hEE;
    reset_n = 0; #2; reset_n = 1;
    chk("t6_pc0", 32'(pc), 32'h0);
    chk("t6_busy0", 32'(busy), 32'h0);
    chk("t6_rd0", 32'(mem_rd), 32'h0);
    step();
    chk("t6_no_load", 32'(ir_load), 32'h0);
    chk("t6_instr0", 32'(instr_out), 32'h0);
    mem_ack = 0;
    $display("txn reset_in_req pc=%0h ir_load=%0b", pc, ir_load);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset_n   = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      fetch_req = 1'($urandom_range(0, 1));
      jump      = ($urandom_range(0, 9) == 0);
      halt      = ($urandom_range(0, 99) < 2);
      jump_addr = ADDR_W'($urandom);
      mem_ack   = ($urandom_range(0, 99) < 40);
      mem_data  = DATA_W'($urandom);
      step();
      if (ir_load)
        $display("txn random cycle=%0d instr=%0h pc=%0h", c, instr_out, pc);
    end
    reset_n = 1; fetch_req = 0; jump = 0; halt = 0; mem_ack = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 4, program counter and memory address width.
REQ-002 Parameter DATA_W, default 8, instruction width; upper 4 bits opcode, lower 4 bits operand at the consumer.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 fetch_req  input  1  controller request to fetch the next instruction.
REQ-006 jump  input  1  controller request to load pc from jump_addr.
REQ-007 jump_addr  input  ADDR_W  jump target.
REQ-008 halt  input  1  stop fetching until reset.
REQ-009 mem_rd  output  1  program memory read request.
REQ-010 mem_addr  output  ADDR_W  program memory read address.
REQ-011 mem_ack  input  1  memory read-data-valid strobe.
REQ-012 mem_data  input  DATA_W  memory read data, valid when mem_ack=1.
REQ-013 instr_out  output  DATA_W  fetched instruction, drives the instruction register data input.
REQ-014 ir_load  output  1  one-cycle load strobe to the instruction register.
REQ-015 pc  output  ADDR_W  current program counter.
REQ-016 busy  output  1  high in REQ and LOAD states.
REQ-017 halted  output  1  high in HALTED state.

Function
REQ-018 FSM states: IDLE, REQ, LOAD, HALTED; all outputs registered.
REQ-019 IDLE priority: halt > jump > fetch_req.
REQ-020 IDLE, halt=1 -> HALTED next cycle; HALTED exits only on reset.
REQ-021 IDLE, jump=1 -> pc <= jump_addr next cycle, state stays IDLE, no memory access.
REQ-022 IDLE, fetch_req=1 -> REQ next cycle, mem_rd=1, mem_addr=pc.
REQ-023 REQ: mem_rd and mem_addr held stable until mem_ack is sampled high; wait count unbounded.
REQ-024 REQ, mem_ack=1 -> instr_out <= mem_data, pc <= pc+1 mod 2^ADDR_W, state LOAD, mem_rd=0 next cycle.
REQ-025 LOAD: ir_load=1 for exactly one cycle, then IDLE unconditionally.
REQ-026 Latency: mem_ack sampled in cycle k -> ir_load=1 and instr_out valid in cycle k+1.
REQ-027 instr_out holds its last value outside LOAD.
REQ-028 pc wraps from 2^ADDR_W-1 to 0 with no flag and no stall.
REQ-029 fetch_req, jump and halt outside IDLE are ignored, not queued.
REQ-030 mem_ack outside REQ is ignored.
REQ-031 fetch_req held high continuously -> one fetch per IDLE visit, minimum 3 cycles per instruction with mem_ack in the first REQ cycle.

Reset
REQ-032 reset_n=0 asynchronously forces state IDLE, pc=0, instr_out=0, mem_rd=0, mem_addr=0, ir_load=0, busy=0, halted=0.
REQ-033 reset_n asserted in REQ or LOAD aborts the fetch, suppresses ir_load, and leaves pc=0.
REQ-034 After reset_n deasserts, the first fetch_req fetches address 0.

Verification
REQ-035 Reset, fetch_req=1 one cycle, mem_ack same cycle as mem_rd, mem_data=8'hA5 -> mem_addr=0, ir_load one cycle, instr_out=8'hA5, pc=1.
REQ-036 mem_ack delayed 5 cycles -> mem_rd and mem_addr=pc stable all 5 cycles, ir_load exactly once, one cycle after ack.
REQ-037 pc=15 (ADDR_W=4), fetch with mem_data=8'h3C -> instr_out=8'h3C, pc=0.
REQ-038 IDLE, jump=1 and fetch_req=1 together, jump_addr=4'h9 -> pc=9, no mem_rd that cycle; next fetch_req reads address 9.
REQ-039 halt during REQ -> ignored, fetch completes; halt in IDLE -> halted=1, later fetch_req gives no mem_rd until reset.
REQ-040 reset_n pulsed low while in REQ -> no ir_load, pc=0, state IDLE.
